// File: rtl/neuron_event_arbiter_if.sv
// rtl/neuron_event_arbiter_if.sv - FIFO-bank and event-sink signal bundle of neuron_event_arbiter
// score_min/drop_count exist only when NEURON_EVENT_ARB_FILTER_EN is defined.
interface neuron_event_arbiter_if #(
   parameter int NUM_NEURONS = 4,
   parameter int SCORE_W     = 4,
   parameter int ID_W        = 2
);
   logic [NUM_NEURONS-1:0]         fifo_valid;
   logic [NUM_NEURONS*SCORE_W-1:0] fifo_score;
   logic [NUM_NEURONS-1:0]         fifo_ready;
   logic                           evt_valid;
   logic [ID_W-1:0]                evt_id;
   logic [SCORE_W-1:0]             evt_score;
   logic                           evt_ready;
`ifdef NEURON_EVENT_ARB_FILTER_EN
   logic [SCORE_W-1:0]             score_min;
   logic [15:0]                    drop_count;
`endif

   modport slave (
      input  fifo_valid, fifo_score, evt_ready,
      output fifo_ready, evt_valid, evt_id, evt_score
`ifdef NEURON_EVENT_ARB_FILTER_EN
      , input score_min, output drop_count
`endif
   );

   modport master (
      output fifo_valid, fifo_score, evt_ready,
      input  fifo_ready, evt_valid, evt_id, evt_score
`ifdef NEURON_EVENT_ARB_FILTER_EN
      , output score_min, input drop_count
`endif
   );
endinterface

// File: rtl/neuron_event_arbiter.sv
// rtl/neuron_event_arbiter.sv - round-robin drain of neuron event FIFOs into one registered event slot
// Define NEURON_EVENT_ARB_FILTER_EN to drop heads scoring below score_min and count them.
module neuron_event_arbiter #(
   parameter int NUM_NEURONS = 4,
   parameter int SCORE_W     = 4,
   parameter int ID_W        = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   neuron_event_arbiter_if.slave bus
);
   localparam int              SUM_W   = ID_W + 1;
   localparam logic [SUM_W-1:0] NUM_S  = SUM_W'(NUM_NEURONS);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_NEURONS - 1);

   logic [ID_W-1:0]    r_rr_ptr;
   logic               r_evt_valid;
   logic [ID_W-1:0]    r_evt_id;
   logic [SCORE_W-1:0] r_evt_score;

   logic               w_load_en;
   logic               w_any;
   logic [ID_W-1:0]    w_grant;
   logic [SUM_W-1:0]   w_sum;
   logic               w_pop;
   logic               w_drop;
   logic [SCORE_W-1:0] w_score;
   logic [SCORE_W-1:0] w_heads [NUM_NEURONS];

   for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_heads
      assign w_heads[gi] = bus.fifo_score[gi*SCORE_W +: SCORE_W];
   end

   // Walk the ports starting at rr_ptr with wrap; the first valid one wins.
   always_comb begin
      w_any   = 1'b0;
      w_grant = '0;
      w_sum   = '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
         w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
         if (w_sum >= NUM_S) w_sum = w_sum - NUM_S;
         if (!w_any && bus.fifo_valid[w_sum[ID_W-1:0]]) begin
            w_any   = 1'b1;
            w_grant = w_sum[ID_W-1:0];
         end
      end
   end

   assign w_load_en      = !r_evt_valid || bus.evt_ready;
   assign w_pop          = w_load_en && w_any && !i_rst;
   assign w_score        = w_heads[w_grant];
   assign bus.fifo_ready = w_pop ? (NUM_NEURONS'(1) << w_grant) : '0;

`ifdef NEURON_EVENT_ARB_FILTER_EN
   logic [15:0] r_drop_count;

   assign w_drop         = w_pop && (w_score < bus.score_min);
   assign bus.drop_count = r_drop_count;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_drop_count <= '0;
      else if (w_drop && r_drop_count != 16'hFFFF)
         r_drop_count <= r_drop_count + 16'd1;
   end
`else
   assign w_drop = 1'b0;
`endif

   // A dropped head still pops and advances the pointer, but leaves the slot as if nothing loaded.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr_ptr    <= '0;
         r_evt_valid <= 1'b0;
         r_evt_id    <= '0;
         r_evt_score <= '0;
      end else begin
         if (w_pop && !w_drop) begin
            r_evt_valid <= 1'b1;
            r_evt_id    <= w_grant;
            r_evt_score <= w_score;
         end else if (bus.evt_ready) begin
            r_evt_valid <= 1'b0;
         end
         if (w_pop)
            r_rr_ptr <= (w_grant == LAST_ID) ? '0 : w_grant + ID_W'(1);
      end
   end

   assign bus.evt_valid = r_evt_valid;
   assign bus.evt_id    = r_evt_id;
   assign bus.evt_score = r_evt_score;
endmodule

// File: tb/tb_neuron_event_arbiter.sv
// tb/tb_neuron_event_arbiter.sv - directed vector bench for neuron_event_arbiter
// Filter sequence runs only when NEURON_EVENT_ARB_FILTER_EN is defined.
module tb_neuron_event_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   neuron_event_arbiter_if #(.NUM_NEURONS(4), .SCORE_W(4), .ID_W(2)) bus ();

   neuron_event_arbiter #(.NUM_NEURONS(4), .SCORE_W(4), .ID_W(2)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [15:0] score;
      logic        ready;
      logic [3:0]  exp_fr;
      logic        exp_v;
      logic [1:0]  exp_id;
      logic [3:0]  exp_sc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] v, input logic [15:0] s, input logic rdy,
                      input logic [3:0] fr, input logic ev, input logic [1:0] id, input logic [3:0] sc);
      vec_t t;
      t.rst = r; t.valid = v; t.score = s; t.ready = rdy;
      t.exp_fr = fr; t.exp_v = ev; t.exp_id = id; t.exp_sc = sc;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] s, input logic rdy);
      rst = r;
      bus.fifo_valid = v;
      bus.fifo_score = s;
      bus.evt_ready = rdy;
   endtask

   // Inputs change at posedge+1, fifo_ready is sampled at posedge+4, registers at posedge+1.
   task automatic step(input string tag, input logic [3:0] fr, input logic ev,
                       input logic [1:0] id, input logic [3:0] sc);
      #3;
      chk({tag, ".fifo_ready"}, 32'(bus.fifo_ready), 32'(fr));
      @(posedge clk);
      #1;
      chk({tag, ".evt_valid"}, 32'(bus.evt_valid), 32'(ev));
      chk({tag, ".evt_id"}, 32'(bus.evt_id), 32'(id));
      chk({tag, ".evt_score"}, 32'(bus.evt_score), 32'(sc));
      n_vec++;
   endtask

   initial begin
`ifdef NEURON_EVENT_ARB_FILTER_EN
      bus.score_min = 4'd0;
`endif
      //   rst valid    score     rdy  fr       v     id     sc
      add(1, 4'b1111, 16'h4321, 1, 4'b0000, 0, 2'd0, 4'd0);
      add(1, 4'b1111, 16'h4321, 1, 4'b0000, 0, 2'd0, 4'd0);
      add(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 2'd0, 4'd1);
      add(0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 2'd1, 4'd2);
      add(0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 2'd2, 4'd3);
      add(0, 4'b1111, 16'h4321, 1, 4'b1000, 1, 2'd3, 4'd4);
      add(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 2'd0, 4'd1);
      add(0, 4'b0100, 16'h4321, 1, 4'b0100, 1, 2'd2, 4'd3);
      add(0, 4'b0010, 16'h4321, 1, 4'b0010, 1, 2'd1, 4'd2);
      add(0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 2'd2, 4'd3);
      add(0, 4'b0100, 16'h4921, 1, 4'b0100, 1, 2'd2, 4'd9);
      for (int i = 0; i < 5; i++)
         add(0, 4'b1111, 16'h4921, 0, 4'b0000, 1, 2'd2, 4'd9);
      add(0, 4'b1111, 16'h4921, 1, 4'b1000, 1, 2'd3, 4'd4);
      add(0, 4'b0000, 16'h4921, 1, 4'b0000, 0, 2'd3, 4'd4);
      add(0, 4'b0000, 16'h4921, 1, 4'b0000, 0, 2'd3, 4'd4);
      add(0, 4'b0100, 16'h4921, 1, 4'b0100, 1, 2'd2, 4'd9);
      add(0, 4'b0100, 16'h4921, 1, 4'b0100, 1, 2'd2, 4'd9);
      add(1, 4'b1111, 16'h4921, 1, 4'b0000, 0, 2'd0, 4'd0);
      add(0, 4'b1010, 16'h4921, 0, 4'b0010, 1, 2'd1, 4'd2);
      add(0, 4'b1010, 16'h4921, 0, 4'b0000, 1, 2'd1, 4'd2);
      add(0, 4'b0000, 16'h4921, 1, 4'b0000, 0, 2'd1, 4'd2);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].score, vecs[i].ready);
         step($sformatf("vec%0d", i), vecs[i].exp_fr, vecs[i].exp_v, vecs[i].exp_id, vecs[i].exp_sc);
      end

      // Sustained throughput: all requesting, sink always ready, one event per cycle in order.
      drive(1, 4'b1111, 16'h4321, 1);
      step("thr_rst", 4'b0000, 0, 2'd0, 4'd0);
      for (int k = 0; k < 8; k++) begin
         drive(0, 4'b1111, 16'h4321, 1);
         step($sformatf("thr%0d", k), 4'(1 << (k % 4)), 1, 2'(k % 4), 4'(k % 4 + 1));
      end

`ifdef NEURON_EVENT_ARB_FILTER_EN
      drive(1, 4'b0000, 16'h0073, 1);
      step("flt_rst", 4'b0000, 0, 2'd0, 4'd0);
      chk("flt_rst.drop_count", 32'(bus.drop_count), 32'd0);
      bus.score_min = 4'd5;
      drive(0, 4'b0011, 16'h0073, 1);
      step("flt_drop", 4'b0001, 0, 2'd0, 4'd0);
      chk("flt_drop.drop_count", 32'(bus.drop_count), 32'd1);
      drive(0, 4'b0010, 16'h0073, 1);
      step("flt_pass", 4'b0010, 1, 2'd1, 4'd7);
      chk("flt_pass.drop_count", 32'(bus.drop_count), 32'd1);
      bus.score_min = 4'd0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/neuron_event_arbiter.md
Name: neuron_event_arbiter

Overview:
- Consumer end of the per-neuron event FIFOs: drains NUM_NEURONS neuron_event_fifo output ports into one tagged event stream.
- Round-robin arbitration between FIFOs; one registered output slot carrying neuron ID and score.
- Sits between the neuron event FIFO bank and the downstream event sink (aggregator or readout).

Parameters:
- NUM_NEURONS, 4, number of FIFO input ports (>=2).
- SCORE_W, 4, score width; matches neuron_event_fifo SCORE_W.
- ID_W, 2, neuron ID width; must satisfy 2**ID_W >= NUM_NEURONS.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_valid  input  NUM_NEURONS  per-FIFO head valid; bit i = neuron i.
- fifo_score  input  NUM_NEURONS*SCORE_W  packed head scores; neuron i at [i*SCORE_W +: SCORE_W].
- fifo_ready  output  NUM_NEURONS  per-FIFO pop; combinational; at most one bit high.
- evt_valid  output  1  output event valid (registered).
- evt_id  output  ID_W  neuron index of the event (registered).
- evt_score  output  SCORE_W  score of the event (registered).
- evt_ready  input  1  downstream accept.

Behaviour:
- Reset: synchronous, active-high, single clock. On rst, evt_valid=0, evt_id=0, evt_score=0, rr_ptr=0, all internal counters cleared. fifo_ready=0 while rst=1. Any in-flight event in the slot is discarded.
- Slot free (load_en) = !evt_valid | evt_ready.
- Grant: combinational search from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_NEURONS-1, 0, ..., rr_ptr-1). The first i with fifo_valid[i]=1 wins; g = winner.
- fifo_ready[g] = load_en & any(fifo_valid) & !rst; all other bits 0. fifo_ready never depends on evt_valid of the next cycle.
- On pop (fifo_valid[g] & fifo_ready[g]):
  - evt_valid<=1, evt_id<=g, evt_score<=fifo_score[g].
  - rr_ptr <= (g==NUM_NEURONS-1) ? 0 : g+1.
- evt_ready=1 with no pop: evt_valid<=0; evt_id and evt_score hold their last values.
- Stall (evt_valid=1, evt_ready=0): evt_id and evt_score stable, no pops, rr_ptr unchanged.
- Latency: pop in cycle N gives evt_valid in cycle N+1.
- Throughput: one event per cycle when evt_ready is held high (drain and load in the same cycle).
- No valid inputs: rr_ptr holds, fifo_ready all 0.
- Single requester: it is granted every cycle, regardless of rr_ptr.
- Fairness: no requester waits more than NUM_NEURONS-1 grants.
- fifo_valid deasserting without a pop is tolerated; grant is re-evaluated every cycle.

Optional Feature:
- Macro: NEURON_EVENT_ARB_FILTER_EN.
- Defined:
  - Extra ports: score_min input SCORE_W; drop_count output 16, reset 0.
  - A granted head with fifo_score[g] < score_min (unsigned) is popped (fifo_ready[g]=1, gated by load_en as usual) but not loaded: evt_valid is unchanged by the load.
  - rr_ptr advances as for a normal grant.
  - drop_count increments and saturates at 16'hFFFF.
- Undefined: ports absent; every popped event is forwarded.

Test Plan:
- Reset: assert rst 2 cycles with all fifo_valid=1 -> fifo_ready=0, evt_valid=0, evt_id=0, evt_score=0; first grant after release goes to neuron 0.
- Round robin: all 4 valid, scores 1,2,3,4, evt_ready=1 -> evt_id sequence 0,1,2,3,0 on consecutive cycles, evt_score 1,2,3,4,1, one event per cycle.
- Wrap: rr_ptr=3 after granting neuron 2, only fifo_valid[1]=1 -> neuron 1 granted; next rr_ptr=2.
- Backpressure: event id=2 score=9 held with evt_ready=0 for 5 cycles -> outputs stable, fifo_ready=0 throughout; evt_ready=1 -> next event loads in that same cycle.
- Idle drain: single event, then no valid inputs, evt_ready=1 -> evt_valid falls next cycle, evt_id and evt_score hold.
- Filter (NEURON_EVENT_ARB_FILTER_EN defined): score_min=5, neuron 0 score 3, neuron 1 score 7 -> neuron 0 popped and dropped, drop_count=1; output is id=1 score=7.
